// File: rtl/alu_issue_stage_if.sv
// Decode-to-execute handshake and operand bundle for alu_issue_stage.
// slave is the issue stage's view; master is the view of whatever drives it.
interface alu_issue_stage_if;
    logic        InValid;
    logic        InReady;
    logic [5:0]  Opcode;
    logic [5:0]  Funct;
    logic [4:0]  Shamt;
    logic [15:0] Imm16;
    logic [31:0] RsData;
    logic [31:0] RtData;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [3:0]  ALUCtrl;
    logic [31:0] BusA;
    logic [31:0] BusB;
    logic        Illegal;
    logic        IllegalSeen;

    modport slave (
        input  InValid, Opcode, Funct, Shamt, Imm16, RsData, RtData, Flush, OutReady,
        output InReady, OutValid, ALUCtrl, BusA, BusB, Illegal, IllegalSeen
    );

    modport master (
        output InValid, Opcode, Funct, Shamt, Imm16, RsData, RtData, Flush, OutReady,
        input  InReady, OutValid, ALUCtrl, BusA, BusB, Illegal, IllegalSeen
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue register: decodes MIPS opcode/funct into ALUCtrl + operands behind valid/ready.
// Optional ALU_ISSUE_SKID_EN adds a one-entry skid buffer so InReady is registered.
module alu_issue_stage (
    input  logic              CLK,
    input  logic              Reset_L,
    alu_issue_stage_if.slave  bus
);
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } op_t;

    localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD  = 4'b0010, C_SLL  = 4'b0011,
                           C_SRL = 4'b0100, C_SUB = 4'b0110, C_SLT  = 4'b0111, C_ADDU = 4'b1000,
                           C_SUBU = 4'b1001, C_XOR = 4'b1010, C_SLTU = 4'b1011, C_NOR = 4'b1100,
                           C_SRA = 4'b1101, C_LUI = 4'b1110;

    op_t         dec;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] shamt_ext;

    assign sext_imm  = {{16{bus.Imm16[15]}}, bus.Imm16};
    assign zext_imm  = {16'b0, bus.Imm16};
    assign shamt_ext = {27'b0, bus.Shamt};

    // Undecodable ops fall through with all-zero operands and ill set.
    always_comb begin
        dec = '{ctrl: C_AND, a: 32'b0, b: 32'b0, ill: 1'b1};
        unique case (bus.Opcode)
            6'b000000: begin
                dec = '{ctrl: C_AND, a: bus.RsData, b: bus.RtData, ill: 1'b0};
                unique case (bus.Funct)
                    6'b000000: begin dec.ctrl = C_SLL; dec.a = shamt_ext; end
                    6'b000010: begin dec.ctrl = C_SRL; dec.a = shamt_ext; end
                    6'b000011: begin dec.ctrl = C_SRA; dec.a = shamt_ext; end
                    6'b000100: dec.ctrl = C_SLL;
                    6'b000110: dec.ctrl = C_SRL;
                    6'b000111: dec.ctrl = C_SRA;
                    6'b100000: dec.ctrl = C_ADD;
                    6'b100001: dec.ctrl = C_ADDU;
                    6'b100010: dec.ctrl = C_SUB;
                    6'b100011: dec.ctrl = C_SUBU;
                    6'b100100: dec.ctrl = C_AND;
                    6'b100101: dec.ctrl = C_OR;
                    6'b100110: dec.ctrl = C_XOR;
                    6'b100111: dec.ctrl = C_NOR;
                    6'b101010: dec.ctrl = C_SLT;
                    6'b101011: dec.ctrl = C_SLTU;
                    default:   dec = '{ctrl: C_AND, a: 32'b0, b: 32'b0, ill: 1'b1};
                endcase
            end
            6'b001000, 6'b100011, 6'b101011:
                       dec = '{ctrl: C_ADD,  a: bus.RsData, b: sext_imm, ill: 1'b0};
            6'b001001: dec = '{ctrl: C_ADDU, a: bus.RsData, b: sext_imm, ill: 1'b0};
            6'b001010: dec = '{ctrl: C_SLT,  a: bus.RsData, b: sext_imm, ill: 1'b0};
            6'b001011: dec = '{ctrl: C_SLTU, a: bus.RsData, b: sext_imm, ill: 1'b0};
            6'b001100: dec = '{ctrl: C_AND,  a: bus.RsData, b: zext_imm, ill: 1'b0};
            6'b001101: dec = '{ctrl: C_OR,   a: bus.RsData, b: zext_imm, ill: 1'b0};
            6'b001110: dec = '{ctrl: C_XOR,  a: bus.RsData, b: zext_imm, ill: 1'b0};
            6'b001111: dec = '{ctrl: C_LUI,  a: 32'b0,      b: zext_imm, ill: 1'b0};
            6'b000100, 6'b000101:
                       dec = '{ctrl: C_SUB,  a: bus.RsData, b: bus.RtData, ill: 1'b0};
            default:   dec = '{ctrl: C_AND,  a: 32'b0, b: 32'b0, ill: 1'b1};
        endcase
    end

    op_t  out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic seen_q, seen_d;
    logic in_ready;
    logic in_xfer;
    logic out_fire;

`ifdef ALU_ISSUE_SKID_EN
    op_t  skid_q, skid_d;
    logic skid_full_q, skid_full_d;

    assign in_ready = ~skid_full_q;
`else
    assign in_ready = ~out_valid_q | bus.OutReady;
`endif

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        seen_d      = seen_q;
        out_fire    = out_valid_q & bus.OutReady;
        in_xfer     = bus.InValid & in_ready;
`ifdef ALU_ISSUE_SKID_EN
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (bus.Flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (~out_valid_q | out_fire) begin
            // Output slot frees up: the parked op goes first to keep order.
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = in_xfer;
                if (in_xfer) skid_d = dec;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) out_d = dec;
            end
        end else if (in_xfer) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
`else
        if (bus.Flush) begin
            out_valid_d = 1'b0;
        end else if (in_xfer) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
`endif
        if (in_xfer & ~bus.Flush & dec.ill) seen_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            seen_q      <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
            skid_q      <= '0;
            skid_full_q <= 1'b0;
`endif
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            seen_q      <= seen_d;
`ifdef ALU_ISSUE_SKID_EN
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
`endif
        end
    end

    assign bus.InReady     = in_ready;
    assign bus.OutValid    = out_valid_q;
    assign bus.ALUCtrl     = out_q.ctrl;
    assign bus.BusA        = out_q.a;
    assign bus.BusB        = out_q.b;
    assign bus.Illegal     = out_q.ill;
    assign bus.IllegalSeen = seen_q;
endmodule
